// File: rtl/shift_2.sv
// shift_2: falling-edge serial-in / parallel-out shift register with async active-high reset.
// Optional feature: define SHIFT_2_SYNC_IN_EN to add a two-stage synchroniser on d.
module shift_2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             ck,
    input  logic             d,
    input  logic             res,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             shift_in;

`ifdef SHIFT_2_SYNC_IN_EN
    // Two falling-edge stages in front of q[0]; both clear on reset.
    logic sync1_q;
    logic sync2_q;

    always_ff @(negedge ck or posedge res) begin
        if (res) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign shift_in = sync2_q;
`else
    assign shift_in = d;
`endif

    // MSB falls off the top; no wrap-around into the LSB.
    always_comb begin
        q_d = {q_q[WIDTH-2:0], shift_in};
    end

    always_ff @(negedge ck or posedge res) begin
        if (res) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_shift_2.sv
// Self-checking bench for shift_2 (WIDTH=4, RESET_VAL=0): timed directed sequences, then random d with a history-queue model.
`timescale 1ns/1ps
module tb_shift_2;

    localparam int             W    = 4;
    localparam logic [W-1:0]   RVAL = 4'b0000;

    logic         ck;
    logic         d;
    logic         res;
    logic [W-1:0] q;

    int n_checks;
    int n_errors;

    // Bits captured at falling edges, most recent first; positions past the end read as RVAL.
    logic hist_q[$];

    shift_2 #(
        .WIDTH    (W),
        .RESET_VAL(RVAL)
    ) dut (
        .ck (ck),
        .d  (d),
        .res(res),
        .q  (q)
    );

    // Clock: low at t=0, falling edges at 20, 40, 60, ...
    initial begin
        ck = 1'b0;
        forever #10 ck = ~ck;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic at_time(input longint t);
        longint now;
        now = longint'($time);
        if (t > now) #(t - now);
    endtask

    function automatic logic [W-1:0] model_q();
        logic [W-1:0] v;
        logic [W-1:0] rv;
        rv = RVAL;
        for (int i = 0; i < W; i++) begin
            v[i] = (i < hist_q.size()) ? hist_q[i] : rv[i];
        end
        return v;
    endfunction

    logic [W-1:0] seq_exp [8];
    logic [W-1:0] hold_exp[6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        seq_exp  = '{4'b0001, 4'b0011, 4'b0110, 4'b1101, 4'b1010, 4'b0100, 4'b1000, 4'b0000};
        hold_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};

        // Reset pulse from t=0, released before the first falling edge.
        res = 1'b1;
        d   = 1'b0;
        at_time(5);
        res = 1'b0;
        at_time(10);
        check("reset_before_edge", q, 4'b0000);

        // Serial sequence with d windows between falling edges.
        fork
            begin
                at_time(15); d = 1'b1;
                at_time(25); d = 1'b0;
                at_time(35); d = 1'b1;
                at_time(45); d = 1'b0;
                at_time(75); d = 1'b1;
                at_time(85); d = 1'b0;
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    at_time(22 + 20 * k);
                    check($sformatf("seq_edge%0d", k + 1), q, seq_exp[k]);
                end
            end
        join

        // d held high for six falling edges (180..280).
        at_time(165); d = 1'b1;
        for (int k = 0; k < 6; k++) begin
            at_time(182 + 20 * k);
            check($sformatf("hold1_edge%0d", k + 1), q, hold_exp[k]);
        end

        // Walk to 1101: shift in 0 then 1.
        at_time(285); d = 1'b0;
        at_time(302); check("walk_1110", q, 4'b1110);
        at_time(305); d = 1'b1;
        at_time(322); check("walk_1101", q, 4'b1101);

        // d pulse straddling the rising edge at 330 only.
        at_time(325); d = 1'b0;
        at_time(328); d = 1'b1;
        at_time(332); d = 1'b0;
        at_time(333); check("rise_pulse_no_change", q, 4'b1101);

        // Async reset 336..341, spanning the falling edge at 340.
        at_time(336); res = 1'b1;
        at_time(338); check("async_reset_immediate", q, 4'b0000);
        at_time(339); d = 1'b1;
        at_time(341); res = 1'b0;
        at_time(342); check("edge_ignored_in_reset", q, 4'b0000);
        at_time(362); check("resume_after_reset", q, 4'b0001);

        // Random phase: fresh reset so the model starts from RVAL.
        at_time(365); res = 1'b1;
        at_time(367); check("rand_start_reset", q, RVAL);
        hist_q.delete();
        at_time(369); res = 1'b0;
        d = 1'($urandom_range(0, 1));

        for (int n = 0; n < 200; n++) begin
            @(negedge ck);
            hist_q.push_front(d);
            if (hist_q.size() > W) void'(hist_q.pop_back());
            #2;
            check($sformatf("rand_edge%0d", n), q, model_q());
            #3;
            d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) begin
                #2 res = 1'b1;
                #3;
                hist_q.delete();
                check($sformatf("rand_reset%0d", n), q, model_q());
                #2 res = 1'b0;
            end
        end

        // Idle clock-low hold: q must persist with no edges.
        #5;
        check("idle_persist", q, model_q());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
